// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key monitor: frame FSM states,
// scan-code prefixes and the bit layout of a key event.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  localparam int EVT_CODE_LSB = 0;
  localparam int EVT_BRK_BIT  = 8;
  localparam int EVT_EXT_BIT  = 9;
  localparam int EVENT_W      = 10;

  // PS/2 uses odd parity: the data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw lines and assembles 11-bit frames.
// It emits a one-cycle byte strobe for good frames and a one-cycle error pulse otherwise.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, clk_s3;
  logic          data_s1, data_s2;
  logic          fall;
  rx_state_t     state;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] idle_cnt;

  assign fall = clk_s3 & ~clk_s2;

  // The synchronisers reset to the idle-high line level so that reset cannot fake an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2Clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2Data;
      data_s2 <= data_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shift       <= '0;
      bit_cnt     <= '0;
      par_bit     <= 1'b0;
      idle_cnt    <= '0;
      rx_byte     <= '0;
      byte_strobe <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      frame_error <= 1'b0;
      if (state != IDLE && !fall && idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state       <= IDLE;
        idle_cnt    <= '0;
        shift       <= '0;
        bit_cnt     <= '0;
        frame_error <= 1'b1;
      end else begin
        if (state == IDLE || fall) idle_cnt <= '0;
        else                       idle_cnt <= idle_cnt + 1'b1;
        if (fall) begin
          case (state)
            IDLE: begin
              if (!data_s2) begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
            DATA: begin
              shift   <= {data_s2, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
              par_bit <= data_s2;
              state   <= STOP;
            end
            STOP: begin
              if (data_s2 && odd_parity_ok(shift, par_bit)) begin
                rx_byte     <= shift;
                byte_strobe <= 1'b1;
              end else begin
                frame_error <= 1'b1;
              end
              state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_monitor.sv
// PS/2 key monitor: decodes E0/F0 prefixes into key events, queues them in a FIFO
// and drives an LED display from one of four selectable sources.
module ps2_key_monitor
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  input  logic [1:0] mode,
  input  logic       pop,
  output logic       eventValid,
  output logic [9:0] eventData,
  output logic       overflow,
  output logic       frameErr,
  output logic [7:0] led
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]         rx_byte;
  logic               byte_strobe;
  logic               frame_error;
  logic               ext, brk;
  logic [7:0]         last_byte;
  logic [7:0]         event_count;
  logic [EVENT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               is_prefix, push_req, pop_ok, full, push_ok;
  logic [EVENT_W-1:0] new_event;
  logic [7:0]         led_next;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .ps2Clk      (ps2Clk),
    .ps2Data     (ps2Data),
    .rx_byte     (rx_byte),
    .byte_strobe (byte_strobe),
    .frame_error (frame_error)
  );

  assign is_prefix  = (rx_byte == PREFIX_EXT) || (rx_byte == PREFIX_BRK);
  assign push_req   = byte_strobe & ~is_prefix;
  assign pop_ok     = pop & eventValid;
  assign full       = (count == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign push_ok    = push_req & (~full | pop_ok);
  assign new_event  = {ext, brk, rx_byte};
  assign eventValid = (count != '0);
  assign eventData  = eventValid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      last_byte   <= '0;
      event_count <= '0;
      overflow    <= 1'b0;
      frameErr    <= 1'b0;
    end else begin
      if (byte_strobe) begin
        last_byte <= rx_byte;
        if (rx_byte == PREFIX_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == PREFIX_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
      if (push_ok) event_count <= event_count + 8'd1;
      if (push_req && full && !pop_ok) overflow <= 1'b1;
      if (frame_error) frameErr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= new_event;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    led_next = '0;
    case (mode)
      2'd0:    led_next = last_byte;
      2'd1:    led_next = eventData[EVT_CODE_LSB +: 8];
      2'd2:    led_next = {overflow, frameErr, ext, brk, 4'(count)};
      default: led_next = event_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) led <= '0;
    else       led <= led_next;
  end

endmodule
